jump_btb: RTL and testbench

//  Parametrised branch target buffer for the fst core, sitting between ID (lookup) and MEM (resolve).

---
 rtl/jump_btb_pkg.sv | 32 +++
 rtl/jump_btb_if.sv | 37 +++
 rtl/jump_btb_pend_fifo.sv | 70 +++++++
 rtl/jump_btb.sv | 133 +++++++++++++
 tb/tb_jump_btb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/jump_btb_pkg.sv
// ============================================================================
// Module : jpred_pkg
// Brief  : Shared types and counter constants for the jump BTB.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpred_pkg;

   localparam int PEND_ADDR_W = 16;

   typedef struct packed {
      logic [PEND_ADDR_W-1:0] pcinc;
      logic                   taken;
      logic [PEND_ADDR_W-1:0] target;
   } pend_entry_t;

   localparam logic [1:0] CNT_WEAK_T = 2'b10;
   localparam logic [1:0] CNT_MAX    = 2'b11;
   localparam logic [1:0] CNT_MIN    = 2'b00;

   function automatic logic [1:0] f_cnt_inc(input logic [1:0] c);
      return (c == CNT_MAX) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] f_cnt_dec(input logic [1:0] c);
      return (c == CNT_MIN) ? c : c - 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jump_btb_if.sv
// ============================================================================
// Module : jump_btb_if
// Brief  : Lookup (ID), resolve (MEM) and redirect signals of the jump BTB.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jump_btb_if #(
   parameter int ADDR_W = 16
);
   logic              lookup_valid;
   logic [ADDR_W-1:0] lookup_pcinc;
   logic              lookup_ready;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              resolve_valid;
   logic              resolve_taken;
   logic [ADDR_W-1:0] resolve_target;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              dir_miss;
   logic              tgt_miss;

   modport master (
      output lookup_valid, lookup_pcinc, resolve_valid, resolve_taken, resolve_target,
      input  lookup_ready, pred_taken, pred_target, redirect_valid, redirect_pc,
             dir_miss, tgt_miss
   );

   modport slave (
      input  lookup_valid, lookup_pcinc, resolve_valid, resolve_taken, resolve_target,
      output lookup_ready, pred_taken, pred_target, redirect_valid, redirect_pc,
             dir_miss, tgt_miss
   );
endinterface

`default_nettype wire

// File: rtl/jump_btb_pend_fifo.sv
// ============================================================================
// Module : jpred_pend_fifo
// Brief  : In-order queue of unresolved predictions with whole-queue flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpred_pend_fifo
   import jpred_pkg::*;
#(
   parameter int  INFLIGHT = 2,
   parameter type T        = pend_entry_t
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  i_push,
   input  T     i_data,
   input  wire  i_pop,
   input  wire  i_flush,
   output logic o_full,
   output logic o_empty,
   output T     o_head
);

   localparam int c_PTR_W = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
   localparam int c_CNT_W = $clog2(INFLIGHT + 1);

   T                    r_mem [INFLIGHT];
   logic [c_PTR_W-1:0]  r_wr;
   logic [c_PTR_W-1:0]  r_rd;
   logic [c_CNT_W-1:0]  r_count;
   logic                w_push;
   logic                w_pop;

   function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_W'(INFLIGHT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full  = (r_count == c_CNT_W'(INFLIGHT));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd];
   assign w_pop   = i_pop & ~o_empty;
   // When full, a push is only legal because the popped slot is freed this edge.
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= f_next(r_wr);
         if (w_pop)  r_rd <= f_next(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/jump_btb.sv
// ============================================================================
// Module : jump_btb
// Brief  : Direct-mapped branch target buffer with 2-bit direction counters
//          and a pending-prediction queue; raises redirect on mispredict.
//          Optional macro JPRED_TAG_EN adds per-entry tags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_btb
   import jpred_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int IDX_W    = 4,
   parameter int TAG_W    = 4,
   parameter int INFLIGHT = 2
) (
   input wire        clk,
   input wire        reset,
   jump_btb_if.slave bus
);

   localparam int c_ENTRIES = 1 << IDX_W;

   typedef struct packed {
      logic [ADDR_W-1:0] pcinc;
      logic              taken;
      logic [ADDR_W-1:0] target;
   } pend_t;

   logic [c_ENTRIES-1:0] r_valid;
   logic [1:0]           r_cnt    [c_ENTRIES];
   logic [ADDR_W-1:0]    r_target [c_ENTRIES];

   logic [IDX_W-1:0] w_lidx;
   logic [IDX_W-1:0] w_ridx;
   logic             w_lhit;
   logic             w_rhit;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_redirect;
   logic             w_dir_miss;
   logic             w_tgt_miss;
   pend_t            w_head;
   pend_t            w_push_data;
   logic             w_unused_bits;

   assign w_lidx = bus.lookup_pcinc[IDX_W-1:0];
   assign w_ridx = w_head.pcinc[IDX_W-1:0];

`ifdef JPRED_TAG_EN
   logic [TAG_W-1:0] r_tag [c_ENTRIES];
   logic [TAG_W-1:0] w_ltag;
   logic [TAG_W-1:0] w_rtag;

   assign w_ltag = bus.lookup_pcinc[IDX_W+TAG_W-1:IDX_W];
   assign w_rtag = w_head.pcinc[IDX_W+TAG_W-1:IDX_W];
   assign w_lhit = r_valid[w_lidx] & (r_tag[w_lidx] == w_ltag);
   assign w_rhit = r_valid[w_ridx] & (r_tag[w_ridx] == w_rtag);
`else
   assign w_lhit = r_valid[w_lidx];
   assign w_rhit = r_valid[w_ridx];
`endif

   assign w_unused_bits = ^{bus.lookup_pcinc, w_head.pcinc};

   // Resolve acts on the head only when something is pending.
   assign w_pop      = bus.resolve_valid & ~w_empty;
   assign w_dir_miss = w_pop & (w_head.taken ^ bus.resolve_taken);
   assign w_tgt_miss = w_pop & w_head.taken & bus.resolve_taken
                     & (w_head.target != bus.resolve_target);
   assign w_redirect = w_dir_miss | w_tgt_miss;

   // A flushing cycle refuses the lookup so ID holds it for the refetched path.
   assign bus.lookup_ready   = ~w_redirect & (~w_full | w_pop);
   assign w_push             = bus.lookup_valid & bus.lookup_ready;
   assign bus.pred_taken     = w_push & w_lhit & r_cnt[w_lidx][1];
   assign bus.pred_target    = r_target[w_lidx];

   assign bus.redirect_valid = w_redirect;
   assign bus.dir_miss       = w_dir_miss;
   assign bus.tgt_miss       = w_tgt_miss;
   assign bus.redirect_pc    = bus.resolve_taken ? bus.resolve_target : w_head.pcinc;

   assign w_push_data.pcinc  = bus.lookup_pcinc;
   assign w_push_data.taken  = bus.pred_taken;
   assign w_push_data.target = bus.pred_target;

   jpred_pend_fifo #(
      .INFLIGHT (INFLIGHT),
      .T        (pend_t)
   ) u_pend (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         for (int i = 0; i < c_ENTRIES; i++) begin
            r_cnt[i]    <= CNT_MIN;
            r_target[i] <= '0;
`ifdef JPRED_TAG_EN
            r_tag[i]    <= '0;
`endif
         end
      end else if (w_pop) begin
         if (bus.resolve_taken) begin
            r_target[w_ridx] <= bus.resolve_target;
            r_valid[w_ridx]  <= 1'b1;
            // A miss here is an allocation (or tag replacement): start weakly taken.
            r_cnt[w_ridx]    <= w_rhit ? f_cnt_inc(r_cnt[w_ridx]) : CNT_WEAK_T;
`ifdef JPRED_TAG_EN
            r_tag[w_ridx]    <= w_rtag;
`endif
         end else if (w_rhit) begin
            r_cnt[w_ridx] <= f_cnt_dec(r_cnt[w_ridx]);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jump_btb.sv
// ============================================================================
// Module : tb_jump_btb
// Brief  : Directed vector bench for jump_btb (ADDR_W=16, IDX_W=4, INFLIGHT=2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_btb;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   jump_btb_if #(.ADDR_W(16)) bus ();

   jump_btb #(
      .ADDR_W   (16),
      .IDX_W    (4),
      .TAG_W    (4),
      .INFLIGHT (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef JPRED_TAG_EN
   localparam bit c_ALIAS_HIT = 1'b0;
`else
   localparam bit c_ALIAS_HIT = 1'b1;
`endif

   typedef struct {
      bit          lv;
      logic [15:0] lpc;
      bit          rv;
      bit          rt;
      logic [15:0] rtgt;
      bit          e_rdy;
      bit          e_pred;
      bit          chk_tgt;
      logic [15:0] e_tgt;
      bit          e_red;
      logic [15:0] e_rpc;
      bit          e_dir;
      bit          e_tmiss;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t v(bit lv, logic [15:0] lpc, bit rv, bit rt, logic [15:0] rtgt,
                              bit rdy, bit pred, bit ct, logic [15:0] tgt,
                              bit red, logic [15:0] rpc, bit dm, bit tm);
      vec_t r;
      r.lv = lv; r.lpc = lpc; r.rv = rv; r.rt = rt; r.rtgt = rtgt;
      r.e_rdy = rdy; r.e_pred = pred; r.chk_tgt = ct; r.e_tgt = tgt;
      r.e_red = red; r.e_rpc = rpc; r.e_dir = dm; r.e_tmiss = tm;
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit lv, input logic [15:0] lpc, input bit rv, input bit rt,
                        input logic [15:0] rtgt);
      bus.lookup_valid   = lv;
      bus.lookup_pcinc   = lpc;
      bus.resolve_valid  = rv;
      bus.resolve_taken  = rt;
      bus.resolve_target = rtgt;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

      //      lv lpc      rv rt rtgt      rdy pred ct tgt      red rpc      dm tm
      vq.push_back(v(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      // cold miss then trained hit
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0040, 0, 0, 0, 16'h0000, 1, 16'h0040, 1, 0));
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0040, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0040, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      // hysteresis on 0x0012
      vq.push_back(v(1, 16'h0012, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0050, 0, 0, 0, 16'h0000, 1, 16'h0050, 1, 0));
      vq.push_back(v(1, 16'h0012, 0, 0, 16'h0000, 1, 1, 1, 16'h0050, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0050, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(1, 16'h0012, 0, 0, 16'h0000, 1, 1, 1, 16'h0050, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0012, 1, 0));
      vq.push_back(v(1, 16'h0012, 0, 0, 16'h0000, 1, 1, 1, 16'h0050, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0012, 1, 0));
      vq.push_back(v(1, 16'h0012, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      // target change
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0040, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0080, 0, 0, 0, 16'h0000, 1, 16'h0080, 0, 1));
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0080, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0080, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      // queue full, push+pop while full
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0080, 0, 16'h0000, 0, 0));
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0080, 0, 16'h0000, 0, 0));
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(1, 16'h0011, 1, 1, 16'h0080, 1, 1, 1, 16'h0080, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      // flush with same-cycle lookup, then stray resolve on empty queue
      vq.push_back(v(1, 16'h0011, 1, 1, 16'h0090, 0, 0, 0, 16'h0000, 1, 16'h0090, 0, 1));
      vq.push_back(v(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h00A0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0090, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0090, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      // aliasing pcinc 0x0021 onto index 1
      vq.push_back(v(1, 16'h0021, 0, 0, 16'h0000, 1, c_ALIAS_HIT, 1, 16'h0090, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 0, 16'h0000, !c_ALIAS_HIT, 0, 0, 16'h0000,
                     c_ALIAS_HIT, 16'h0021, c_ALIAS_HIT, 0));
      vq.push_back(v(1, 16'h0011, 0, 0, 16'h0000, 1, 1, 1, 16'h0090, 0, 16'h0000, 0, 0));
      vq.push_back(v(0, 16'h0000, 1, 1, 16'h0090, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));

      // outputs while reset is held
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset lookup_ready", 16'(bus.lookup_ready), 16'h1);
      chk("reset pred_taken", 16'(bus.pred_taken), 16'h0);
      chk("reset redirect_valid", 16'(bus.redirect_valid), 16'h0);
      chk("reset dir_miss", 16'(bus.dir_miss), 16'h0);
      chk("reset tgt_miss", 16'(bus.tgt_miss), 16'h0);
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].lv, vq[i].lpc, vq[i].rv, vq[i].rt, vq[i].rtgt);
         #1;
         chk($sformatf("v%0d lookup_ready", i), 16'(bus.lookup_ready), 16'(vq[i].e_rdy));
         chk($sformatf("v%0d pred_taken", i), 16'(bus.pred_taken), 16'(vq[i].e_pred));
         if (vq[i].chk_tgt)
            chk($sformatf("v%0d pred_target", i), bus.pred_target, vq[i].e_tgt);
         chk($sformatf("v%0d redirect_valid", i), 16'(bus.redirect_valid), 16'(vq[i].e_red));
         if (vq[i].e_red)
            chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vq[i].e_rpc);
         chk($sformatf("v%0d dir_miss", i), 16'(bus.dir_miss), 16'(vq[i].e_dir));
         chk($sformatf("v%0d tgt_miss", i), 16'(bus.tgt_miss), 16'(vq[i].e_tmiss));
      end

      // mid-run reset must forget the trained entry and empty the queue
      @(negedge clk);
      drive(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0033);
      #1;
      chk("post-reset stray resolve redirect", 16'(bus.redirect_valid), 16'h0);
      @(negedge clk);
      drive(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000);
      #1;
      chk("post-reset lookup_ready", 16'(bus.lookup_ready), 16'h1);
      chk("post-reset pred_taken", 16'(bus.pred_taken), 16'h0);
      @(negedge clk);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
